// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong game controller.
package pong_pkg;

    localparam logic [2:0]  DEFAULT_WIN_SCORE   = 3'd7;
    localparam logic [25:0] DEFAULT_PERIOD_INIT = 26'd500_000;
    localparam logic [25:0] DEFAULT_PERIOD_MIN  = 26'd50_000;
    localparam logic [7:0]  DEFAULT_SERVE_TICKS = 8'd60;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } pong_state_e;

    // Speed up by 1/8 per point; the floor is applied after the subtraction.
    function automatic logic [25:0] shrink_period(input logic [25:0] period,
                                                  input logic [25:0] floor_val);
        logic [25:0] next;
        next = period - (period >> 3);
        return (next < floor_val) ? floor_val : next;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-control bus between the playfield/tick logic and the pong game controller.
interface pong_game_ctrl_if;
    logic        tick;
    logic        serve_req;
    logic        new_game;
    logic        ball_off_left;
    logic        ball_off_right;
    logic        in_play;
    logic        ball_reset;
    logic [2:0]  lpad_score;
    logic [2:0]  rpad_score;
    logic [25:0] game_period;
    logic        game_over;
    logic        winner;

    modport master (
        output tick, serve_req, new_game, ball_off_left, ball_off_right,
        input  in_play, ball_reset, lpad_score, rpad_score, game_period, game_over, winner
    );

    modport slave (
        input  tick, serve_req, new_game, ball_off_left, ball_off_right,
        output in_play, ball_reset, lpad_score, rpad_score, game_period, game_over, winner
    );
endinterface

// File: rtl/pong_game_ctrl_serve_timer.sv
// Loadable 8-bit tick-decrement counter; done flags the last tick of the serve delay.
module serve_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [7:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 8'd0)) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign done = (count_q == 8'd1);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing: serve delay, point scoring, speed-up and game-over handling.
// Build option: define PONG_AUTO_SERVE_EN to re-serve automatically after a non-winning point.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [2:0]  WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter logic [25:0] PERIOD_INIT = DEFAULT_PERIOD_INIT,
    parameter logic [25:0] PERIOD_MIN  = DEFAULT_PERIOD_MIN,
    parameter logic [7:0]  SERVE_TICKS = DEFAULT_SERVE_TICKS
) (
    input logic             clk,
    input logic             rst,
    pong_game_ctrl_if.slave bus
);

    localparam logic [7:0] SERVE_LOAD = (SERVE_TICKS == 8'd0) ? 8'd1 : SERVE_TICKS;

    pong_state_e state_q, state_d;
    logic [2:0]  lscore_q, lscore_d;
    logic [2:0]  rscore_q, rscore_d;
    logic [25:0] period_q, period_d;
    logic        ball_reset_q, ball_reset_d;
    logic        winner_q, winner_d;
    logic        credit_right_q, credit_right_d;
    logic        in_play_q;
    logic        game_over_q;

    logic timer_load;
    logic timer_dec;
    logic timer_done;

    serve_timer u_serve_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SERVE_LOAD),
        .dec      (timer_dec),
        .done     (timer_done)
    );

    always_comb begin
        state_d        = state_q;
        lscore_d       = lscore_q;
        rscore_d       = rscore_q;
        period_d       = period_q;
        ball_reset_d   = 1'b0;
        winner_d       = winner_q;
        credit_right_d = credit_right_q;
        timer_load     = 1'b0;
        timer_dec      = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.tick && bus.serve_req) begin
                    state_d    = StServe;
                    timer_load = 1'b1;
                end
            end
            StServe: begin
                if (bus.tick) begin
                    timer_dec = 1'b1;
                    if (timer_done) state_d = StPlay;
                end
            end
            StPlay: begin
                if (bus.tick && (bus.ball_off_left || bus.ball_off_right)) begin
                    state_d        = StPoint;
                    ball_reset_d   = 1'b1;
                    period_d       = shrink_period(period_q, PERIOD_MIN);
                    // Left edge has priority when both flags are set.
                    credit_right_d = bus.ball_off_left;
                    if (bus.ball_off_left) begin
                        if (rscore_q < WIN_SCORE) rscore_d = rscore_q + 3'd1;
                    end else begin
                        if (lscore_q < WIN_SCORE) lscore_d = lscore_q + 3'd1;
                    end
                end
            end
            StPoint: begin
                if ((credit_right_q ? rscore_q : lscore_q) == WIN_SCORE) begin
                    state_d  = StOver;
                    winner_d = credit_right_q;
                end else begin
`ifdef PONG_AUTO_SERVE_EN
                    state_d    = StServe;
                    timer_load = 1'b1;
`else
                    state_d    = StIdle;
`endif
                end
            end
            StOver: begin
                if (bus.new_game) begin
                    state_d      = StIdle;
                    lscore_d     = 3'd0;
                    rscore_d     = 3'd0;
                    period_d     = PERIOD_INIT;
                    winner_d     = 1'b0;
                    ball_reset_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            lscore_q       <= 3'd0;
            rscore_q       <= 3'd0;
            period_q       <= PERIOD_INIT;
            ball_reset_q   <= 1'b0;
            winner_q       <= 1'b0;
            credit_right_q <= 1'b0;
            in_play_q      <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lscore_q       <= lscore_d;
            rscore_q       <= rscore_d;
            period_q       <= period_d;
            ball_reset_q   <= ball_reset_d;
            winner_q       <= winner_d;
            credit_right_q <= credit_right_d;
            // Status flags follow the next state so they line up with it.
            in_play_q      <= (state_d == StPlay);
            game_over_q    <= (state_d == StOver);
        end
    end

    assign bus.in_play     = in_play_q;
    assign bus.ball_reset  = ball_reset_q;
    assign bus.lpad_score  = lscore_q;
    assign bus.rpad_score  = rscore_q;
    assign bus.game_period = period_q;
    assign bus.game_over   = game_over_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench: default, WIN_SCORE=2 and PERIOD_INIT=60000 controllers on shared stimulus.
module tb_pong_game_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic tick, serve_req, new_game, off_l, off_r;

    always #5 clk = ~clk;

    pong_game_ctrl_if bus_a ();
    pong_game_ctrl_if bus_b ();
    pong_game_ctrl_if bus_c ();

    assign bus_a.tick = tick;
    assign bus_a.serve_req = serve_req;
    assign bus_a.new_game = new_game;
    assign bus_a.ball_off_left = off_l;
    assign bus_a.ball_off_right = off_r;
    assign bus_b.tick = tick;
    assign bus_b.serve_req = serve_req;
    assign bus_b.new_game = new_game;
    assign bus_b.ball_off_left = off_l;
    assign bus_b.ball_off_right = off_r;
    assign bus_c.tick = tick;
    assign bus_c.serve_req = serve_req;
    assign bus_c.new_game = new_game;
    assign bus_c.ball_off_left = off_l;
    assign bus_c.ball_off_right = off_r;

    pong_game_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pong_game_ctrl #(.WIN_SCORE(3'd2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    pong_game_ctrl #(.PERIOD_INIT(26'd60_000)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    typedef struct {
        logic [2:0]  l;
        logic [2:0]  r;
        logic [25:0] period;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    logic [2:0]  m_l;
    logic [2:0]  m_r;
    logic [25:0] m_period;

    function automatic logic [25:0] model_shrink(input logic [25:0] p);
        int unsigned s;
        s = int'(p) - int'(p) / 8;
        if (s < 50_000) s = 50_000;
        return s[25:0];
    endfunction

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic serve_to_play(output int n);
        n = 0;
        while (n < 200) begin
            do_tick();
            n++;
            if (bus_a.in_play === 1'b1) break;
        end
    endtask

    // Drives one scoring tick, queues A's expected result, waits (bounded) for the pulse.
    task automatic score_point(input logic left, input logic right, output logic seen);
        exp_t e;
        m_period = model_shrink(m_period);
        if (left) m_r = m_r + 3'd1;
        else      m_l = m_l + 3'd1;
        e.l = m_l;
        e.r = m_r;
        e.period = m_period;
        exp_q.push_back(e);
        @(negedge clk);
        tick = 1'b1; off_l = left; off_r = right;
        @(negedge clk);
        tick = 1'b0; off_l = 1'b0; off_r = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus_a.ball_reset === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; serve_req = 1'b0; new_game = 1'b0; off_l = 1'b0; off_r = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_l = 3'd0; m_r = 3'd0; m_period = 26'd500_000;
        checks++;
        if ({bus_a.in_play, bus_a.ball_reset, bus_a.game_over, bus_a.winner,
             bus_a.lpad_score, bus_a.rpad_score} !== 10'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0", {bus_a.in_play, bus_a.ball_reset,
                     bus_a.game_over, bus_a.winner, bus_a.lpad_score, bus_a.rpad_score});
        end
        checks++;
        if (bus_a.game_period !== 26'd500_000) begin
            failures++;
            $display("FAIL reset_period: got %0d required 500000", bus_a.game_period);
        end
        checks++;
        if (bus_c.game_period !== 26'd60_000) begin
            failures++;
            $display("FAIL reset_period_c: got %0d required 60000", bus_c.game_period);
        end
    endtask

    task automatic test_serve();
        int n;
        serve_req = 1'b1;
        serve_to_play(n);
        checks++;
        if (n != 61) begin
            failures++;
            $display("FAIL serve_ticks: got %0d ticks required 61", n);
        end
        checks++;
        if ({bus_b.in_play, bus_c.in_play} !== 2'b11) begin
            failures++;
            $display("FAIL serve_in_play_bc: got %b required 11", {bus_b.in_play, bus_c.in_play});
        end
    endtask

    task automatic test_point_left();
        logic seen;
        exp_t e;
        serve_req = 1'b0;
        score_point(1'b0, 1'b1, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL point_left_pulse: ball_reset got 0 required 1");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus_a.lpad_score !== e.l || bus_a.rpad_score !== e.r ||
                bus_a.game_period !== e.period) begin
                failures++;
                $display("FAIL point_left_sb: got %0d/%0d/%0d required %0d/%0d/%0d",
                         bus_a.lpad_score, bus_a.rpad_score, bus_a.game_period,
                         e.l, e.r, e.period);
            end
        end
        checks++;
        if (bus_a.game_period !== 26'd437_500) begin
            failures++;
            $display("FAIL point_left_period: got %0d required 437500", bus_a.game_period);
        end
        checks++;
        if (bus_c.game_period !== 26'd52_500) begin
            failures++;
            $display("FAIL period_c_first: got %0d required 52500", bus_c.game_period);
        end
        @(negedge clk);
        checks++;
        if ({bus_a.ball_reset, bus_a.in_play} !== 2'b00) begin
            failures++;
            $display("FAIL point_pulse_width: got %b required 00",
                     {bus_a.ball_reset, bus_a.in_play});
        end
    endtask

    task automatic test_after_point();
        int n;
        n = 0;
        while (n < 60) begin
            do_tick();
            n++;
            if (bus_a.in_play === 1'b1) break;
        end
`ifdef PONG_AUTO_SERVE_EN
        checks++;
        if (n != 60 || bus_a.in_play !== 1'b1) begin
            failures++;
            $display("FAIL auto_serve: got %0d ticks in_play=%b required 60 ticks in_play=1",
                     n, bus_a.in_play);
        end
`else
        checks++;
        if (bus_a.in_play !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_point: in_play got %b required 0", bus_a.in_play);
        end
        serve_req = 1'b1;
        serve_to_play(n);
        checks++;
        if (n != 61) begin
            failures++;
            $display("FAIL reserve_ticks: got %0d required 61", n);
        end
`endif
    endtask

    task automatic test_both_off();
        logic seen;
        exp_t e;
        int n;
        score_point(1'b1, 1'b1, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL both_off_pulse: ball_reset got 0 required 1");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus_a.lpad_score !== e.l || bus_a.rpad_score !== e.r ||
                bus_a.game_period !== e.period) begin
                failures++;
                $display("FAIL both_off_sb: got %0d/%0d/%0d required %0d/%0d/%0d",
                         bus_a.lpad_score, bus_a.rpad_score, bus_a.game_period,
                         e.l, e.r, e.period);
            end
        end
        checks++;
        if (bus_c.game_period !== 26'd50_000) begin
            failures++;
            $display("FAIL period_clamp: got %0d required 50000", bus_c.game_period);
        end
        serve_req = 1'b1;
        serve_to_play(n);
        checks++;
`ifdef PONG_AUTO_SERVE_EN
        if (n != 60) begin
            failures++;
            $display("FAIL serve_after_both: got %0d ticks required 60", n);
        end
`else
        if (n != 61) begin
            failures++;
            $display("FAIL serve_after_both: got %0d ticks required 61", n);
        end
`endif
    endtask

    task automatic test_win();
        logic seen;
        exp_t e;
        score_point(1'b1, 1'b0, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL win_pulse: ball_reset got 0 required 1");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus_a.lpad_score !== e.l || bus_a.rpad_score !== e.r ||
                bus_a.game_period !== e.period) begin
                failures++;
                $display("FAIL win_sb: got %0d/%0d/%0d required %0d/%0d/%0d",
                         bus_a.lpad_score, bus_a.rpad_score, bus_a.game_period,
                         e.l, e.r, e.period);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_b.game_over, bus_b.winner, bus_b.in_play, bus_b.lpad_score,
             bus_b.rpad_score} !== 9'b110_001_010) begin
            failures++;
            $display("FAIL game_over_b: got %b required 110001010", {bus_b.game_over,
                     bus_b.winner, bus_b.in_play, bus_b.lpad_score, bus_b.rpad_score});
        end
        checks++;
        if (bus_c.game_period !== 26'd50_000 || bus_c.game_over !== 1'b0) begin
            failures++;
            $display("FAIL period_hold_c: got %0d over=%b required 50000 over=0",
                     bus_c.game_period, bus_c.game_over);
        end
        off_l = 1'b1;
        do_tick();
        do_tick();
        off_l = 1'b0;
        checks++;
        if ({bus_b.game_over, bus_b.lpad_score, bus_b.rpad_score} !== 7'b1_001_010) begin
            failures++;
            $display("FAIL over_frozen: got %b required 1001010",
                     {bus_b.game_over, bus_b.lpad_score, bus_b.rpad_score});
        end
        @(negedge clk) new_game = 1'b1;
        @(negedge clk) new_game = 1'b0;
        checks++;
        if ({bus_b.ball_reset, bus_b.game_over, bus_b.winner, bus_b.lpad_score,
             bus_b.rpad_score} !== 9'b100_000_000 || bus_b.game_period !== 26'd500_000) begin
            failures++;
            $display("FAIL new_game_b: got %b period %0d required 100000000 period 500000",
                     {bus_b.ball_reset, bus_b.game_over, bus_b.winner, bus_b.lpad_score,
                      bus_b.rpad_score}, bus_b.game_period);
        end
        checks++;
        if ({bus_a.ball_reset, bus_a.lpad_score, bus_a.rpad_score} !== 7'b0_001_010) begin
            failures++;
            $display("FAIL new_game_ignored_a: got %b required 0001010",
                     {bus_a.ball_reset, bus_a.lpad_score, bus_a.rpad_score});
        end
        @(negedge clk);
        checks++;
        if (bus_b.ball_reset !== 1'b0) begin
            failures++;
            $display("FAIL new_game_pulse_width: got %b required 0", bus_b.ball_reset);
        end
    endtask

    task automatic test_rst_mid_game();
        int n;
        serve_req = 1'b1;
        do_tick();
        do_tick();
        @(negedge clk);
        rst = 1'b1; new_game = 1'b1; tick = 1'b1; serve_req = 1'b1;
        @(negedge clk);
        rst = 1'b0; new_game = 1'b0; tick = 1'b0;
        checks++;
        if ({bus_a.in_play, bus_a.ball_reset, bus_a.game_over, bus_a.winner, bus_a.lpad_score,
             bus_a.rpad_score} !== 10'd0 || bus_a.game_period !== 26'd500_000) begin
            failures++;
            $display("FAIL rst_mid_serve: got %b period %0d required 0 period 500000",
                     {bus_a.in_play, bus_a.ball_reset, bus_a.game_over, bus_a.winner,
                      bus_a.lpad_score, bus_a.rpad_score}, bus_a.game_period);
        end
        checks++;
        if ({bus_b.ball_reset, bus_b.game_over} !== 2'b00) begin
            failures++;
            $display("FAIL rst_priority_b: got %b required 00",
                     {bus_b.ball_reset, bus_b.game_over});
        end
        m_l = 3'd0; m_r = 3'd0; m_period = 26'd500_000;
        serve_to_play(n);
        checks++;
        if (n != 61) begin
            failures++;
            $display("FAIL serve_after_rst: got %0d ticks required 61", n);
        end
        @(negedge clk);
        tick = 1'b1; off_r = 1'b1;
        @(negedge clk);
        tick = 1'b0; off_r = 1'b0;
        checks++;
        if ({bus_a.ball_reset, bus_a.lpad_score} !== 4'b1_001) begin
            failures++;
            $display("FAIL point_before_rst: got %b required 1001",
                     {bus_a.ball_reset, bus_a.lpad_score});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus_a.in_play, bus_a.ball_reset, bus_a.lpad_score, bus_a.rpad_score} !== 8'd0 ||
            bus_a.game_period !== 26'd500_000) begin
            failures++;
            $display("FAIL rst_in_point: got %b period %0d required 0 period 500000",
                     {bus_a.in_play, bus_a.ball_reset, bus_a.lpad_score, bus_a.rpad_score},
                     bus_a.game_period);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_serve();
        test_point_left();
        test_after_point();
        test_both_off();
        test_win();
        test_rst_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
